// File: rtl/mips_cpu_bus_arbiter_if.sv
// mips_cpu_bus_arbiter_if
//   Bundles the requester-side channels and the Avalon-MM bus of the CPU bus
//   arbiter.
//   modport master : the arbiter, which is the Avalon master
//   modport slave  : the environment (requesters plus Avalon slave)
//   Requester side: ch_req/ch_write/ch_addr/ch_size/ch_signed/ch_wdata in,
//                   ch_ack/ch_err/rdata out, busy out.
//   Avalon side   : address/read/write/writedata/byteenable out,
//                   waitrequest/readdata in.
//   Handshake: a requester raises ch_req with all of its fields stable and
//   holds them until it sees ch_ack (a one-cycle pulse, qualified by ch_err).
//   On the bus, a cycle completes at the first rising edge where read or
//   write is high and waitrequest is low.
interface mips_cpu_bus_arbiter_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [NUM_CH-1:0]        ch_req;
  logic [NUM_CH-1:0]        ch_write;
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic [NUM_CH*2-1:0]      ch_size;
  logic [NUM_CH-1:0]        ch_signed;
  logic [NUM_CH*DATA_W-1:0] ch_wdata;
  logic [NUM_CH-1:0]        ch_ack;
  logic [NUM_CH-1:0]        ch_err;
  logic [DATA_W-1:0]        rdata;
  logic                     busy;
  logic [ADDR_W-1:0]        address;
  logic                     write;
  logic                     read;
  logic                     waitrequest;
  logic [DATA_W-1:0]        writedata;
  logic [DATA_W/8-1:0]      byteenable;
  logic [DATA_W-1:0]        readdata;

  modport master (
    input  ch_req, ch_write, ch_addr, ch_size, ch_signed, ch_wdata,
    input  waitrequest, readdata,
    output ch_ack, ch_err, rdata, busy,
    output address, write, read, writedata, byteenable
  );

  modport slave (
    output ch_req, ch_write, ch_addr, ch_size, ch_signed, ch_wdata,
    output waitrequest, readdata,
    input  ch_ack, ch_err, rdata, busy,
    input  address, write, read, writedata, byteenable
  );
endinterface

// File: rtl/mips_cpu_bus_arbiter.sv
// mips_cpu_bus_arbiter
//   Avalon-MM master shared by NUM_CH requesters (ch0 = fetch, ch1 = data).
//   Grants one request at a time, runs one bus cycle (held through
//   waitrequest), steers byte lanes for stores and extracts/extends loads.
//   Misaligned or illegal-size accesses get an error ack and no bus cycle.
//   Ports:
//     clk       : rising-edge clock
//     reset     : asynchronous, active-low
//     bus       : mips_cpu_bus_arbiter_if.master (requesters + Avalon)
//     dbg_state : current FSM state (0 IDLE, 1 BUS, 2 RESP)
//   Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration;
//   otherwise fixed priority with the lowest channel index winning.
module mips_cpu_bus_arbiter #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  mips_cpu_bus_arbiter_if.master bus,
  output logic [1:0]            dbg_state
);
  localparam int BE_W   = DATA_W / 8;
  localparam int LANE_W = $clog2(BE_W);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        state;
  logic [CH_W-1:0]   gnt_q;
  logic              lat_write;
  logic              lat_signed;
  logic [ADDR_W-1:0] lat_addr;
  logic [1:0]        lat_size;
  logic [DATA_W-1:0] lat_wdata;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;

  logic [CH_W-1:0]   gnt_sel;
  logic              any_req;
  logic              sel_write;
  logic              sel_signed;
  logic [ADDR_W-1:0] sel_addr;
  logic [1:0]        sel_size;
  logic [DATA_W-1:0] sel_wdata;

  logic [LANE_W-1:0]   lane;
  logic [LANE_W+2:0]   shamt;
  logic                in_bus;

  // Natural alignment plus size legality (dword only exists on a 64-bit bus).
  function automatic logic is_aligned(input logic [ADDR_W-1:0] a, input logic [1:0] s);
    logic ok;
    case (s)
      2'd0:    ok = 1'b1;
      2'd1:    ok = ~a[0];
      2'd2:    ok = (a[1:0] == 2'b00);
      default: ok = (DATA_W == 64) && (a[2:0] == 3'b000);
    endcase
    return ok;
  endfunction

  // Bit mask covering the low 2^s bytes.
  function automatic logic [DATA_W-1:0] size_mask(input logic [1:0] s);
    logic [DATA_W-1:0] m;
    for (int b = 0; b < DATA_W; b++) m[b] = (b < (8 << s));
    return m;
  endfunction

  // Byte-lane mask covering the low 2^s lanes.
  function automatic logic [BE_W-1:0] lane_mask(input logic [1:0] s);
    logic [BE_W-1:0] m;
    for (int i = 0; i < BE_W; i++) m[i] = (i < (1 << s));
    return m;
  endfunction

  // Truncate right-justified load data to its size, then zero/sign extend.
  // A full-width load has no bits above it, so nothing is extended.
  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] d,
                                               input logic [1:0] s, input logic sgn);
    logic [DATA_W-1:0] r;
    r = d & size_mask(s);
    for (int b = 0; b < DATA_W; b++) begin
      case (s)
        2'd0:    if (b >= 8)  r[b] = sgn & d[7];
        2'd1:    if (b >= 16) r[b] = sgn & d[15];
        2'd2:    if (b >= 32) r[b] = sgn & d[31];
        default: ;
      endcase
    end
    return r;
  endfunction

`ifdef ARB_ROUND_ROBIN_EN
  logic [CH_W-1:0] ptr;
  logic [CH_W-1:0] idx;

  // Scan from the farthest channel back to ptr so the one nearest ptr
  // (in rotating order) is assigned last and wins.
  always_comb begin
    gnt_sel = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = CH_W'((int'(ptr) + k) % NUM_CH);
      if (bus.ch_req[idx]) begin
        gnt_sel = idx;
        any_req = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (state == S_IDLE && any_req) begin
      ptr <= (gnt_sel == CH_W'(NUM_CH - 1)) ? '0 : gnt_sel + 1'b1;
    end
  end
`else
  // Fixed priority: scan downwards so the lowest requesting index wins.
  always_comb begin
    gnt_sel = '0;
    any_req = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (bus.ch_req[i]) begin
        gnt_sel = CH_W'(i);
        any_req = 1'b1;
      end
    end
  end
`endif

  // Fields of the channel about to be granted.
  always_comb begin
    sel_write  = 1'b0;
    sel_signed = 1'b0;
    sel_addr   = '0;
    sel_size   = '0;
    sel_wdata  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt_sel == CH_W'(i)) begin
        sel_write  = bus.ch_write[i];
        sel_signed = bus.ch_signed[i];
        sel_addr   = bus.ch_addr[i*ADDR_W +: ADDR_W];
        sel_size   = bus.ch_size[i*2 +: 2];
        sel_wdata  = bus.ch_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      gnt_q      <= '0;
      lat_write  <= 1'b0;
      lat_signed <= 1'b0;
      lat_addr   <= '0;
      lat_size   <= '0;
      lat_wdata  <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            gnt_q      <= gnt_sel;
            lat_write  <= sel_write;
            lat_signed <= sel_signed;
            lat_addr   <= sel_addr;
            lat_size   <= sel_size;
            lat_wdata  <= sel_wdata;
            rdata_q    <= '0;
            if (is_aligned(sel_addr, sel_size)) begin
              err_q <= 1'b0;
              state <= S_BUS;
            end else begin
              err_q <= 1'b1;
              state <= S_RESP;
            end
          end
        end
        S_BUS: begin
          if (!bus.waitrequest) begin
            rdata_q <= lat_write ? '0 : extend(bus.readdata >> shamt, lat_size, lat_signed);
            state   <= S_RESP;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Bus outputs are decoded from state so an asynchronous reset drops them at once.
  assign lane   = lat_addr[LANE_W-1:0];
  assign shamt  = {lane, 3'b000};
  assign in_bus = (state == S_BUS);

  assign bus.address    = in_bus ? {lat_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}} : '0;
  assign bus.read       = in_bus & ~lat_write;
  assign bus.write      = in_bus & lat_write;
  assign bus.byteenable = in_bus ? (lane_mask(lat_size) << lane) : '0;
  assign bus.writedata  = (in_bus & lat_write) ? ((lat_wdata & size_mask(lat_size)) << shamt) : '0;
  assign bus.busy       = (state != S_IDLE);
  assign bus.rdata      = (state == S_RESP) ? rdata_q : '0;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      bus.ch_ack[i] = (state == S_RESP) && (gnt_q == CH_W'(i));
      bus.ch_err[i] = (state == S_RESP) && (gnt_q == CH_W'(i)) && err_q;
    end
  end

  assign dbg_state = state;
endmodule

// File: tb/tb_mips_cpu_bus_arbiter.sv
// tb_mips_cpu_bus_arbiter
//   Directed bench for mips_cpu_bus_arbiter (NUM_CH=2, 32-bit address/data).
//   Expected values are hand-computed from the intended behaviour.
module tb_mips_cpu_bus_arbiter;
  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;

  int vec_cnt = 0;
  int err_cnt = 0;

  mips_cpu_bus_arbiter_if #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32)) bus ();

  mips_cpu_bus_arbiter #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- transaction results ----------------
  int          r_ack_cyc;
  logic [1:0]  r_ack;
  logic [1:0]  r_err;
  logic [31:0] r_rdata;
  int          r_rd_cyc;
  int          r_wr_cyc;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wd;
  logic        r_unstable;

  // ---------------- driver ----------------
  // Presents one request just after a rising edge (cycle 0), samples on
  // falling edges, stalls the bus for wait_n cycles, and records what it sees.
  task automatic run_txn(input int ch, input logic wr, input logic [31:0] addr,
                         input logic [1:0] size, input logic sgn,
                         input logic [31:0] wdata, input logic [31:0] rd_in,
                         input int wait_n);
    r_ack_cyc = -1; r_ack = '0; r_err = '0; r_rdata = '0;
    r_rd_cyc = 0; r_wr_cyc = 0; r_addr = '0; r_be = '0; r_wd = '0; r_unstable = 1'b0;
    bus.readdata    = rd_in;
    bus.waitrequest = (wait_n > 0);
    @(posedge clk); #1;
    bus.ch_write[ch]          = wr;
    bus.ch_addr[ch*32 +: 32]  = addr;
    bus.ch_size[ch*2 +: 2]    = size;
    bus.ch_signed[ch]         = sgn;
    bus.ch_wdata[ch*32 +: 32] = wdata;
    bus.ch_req[ch]            = 1'b1;
    for (int c = 0; c < 40 && r_ack_cyc < 0; c++) begin
      @(negedge clk);
      if (bus.read || bus.write) begin
        if (r_rd_cyc + r_wr_cyc == 0) begin
          r_addr = bus.address; r_be = bus.byteenable; r_wd = bus.writedata;
        end else if (r_addr !== bus.address || r_be !== bus.byteenable || r_wd !== bus.writedata) begin
          r_unstable = 1'b1;
        end
        r_rd_cyc += int'(bus.read);
        r_wr_cyc += int'(bus.write);
        bus.waitrequest = ((r_rd_cyc + r_wr_cyc) <= wait_n);
      end
      if (bus.ch_ack != 2'b00) begin
        r_ack_cyc = c; r_ack = bus.ch_ack; r_err = bus.ch_err; r_rdata = bus.rdata;
      end
    end
    @(posedge clk); #1;
    bus.ch_req[ch]  = 1'b0;
    bus.waitrequest = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    vec_cnt++; if (bus.busy !== 1'b0) begin err_cnt++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    vec_cnt++; if (bus.read !== 1'b0 || bus.write !== 1'b0) begin err_cnt++; $display("FAIL rst_strobes: got rd=%b wr=%b want 0/0", bus.read, bus.write); end
    vec_cnt++; if (bus.address !== 32'h0) begin err_cnt++; $display("FAIL rst_address: got %h want 0", bus.address); end
    vec_cnt++; if (bus.byteenable !== 4'h0 || bus.writedata !== 32'h0) begin err_cnt++; $display("FAIL rst_be_wd: got %h/%h want 0/0", bus.byteenable, bus.writedata); end
    vec_cnt++; if (bus.ch_ack !== 2'b00 || bus.ch_err !== 2'b00) begin err_cnt++; $display("FAIL rst_ack_err: got %b/%b want 00/00", bus.ch_ack, bus.ch_err); end
    vec_cnt++; if (bus.rdata !== 32'h0) begin err_cnt++; $display("FAIL rst_rdata: got %h want 0", bus.rdata); end
    vec_cnt++; if (dbg_state !== 2'd0) begin err_cnt++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_word_read();
    run_txn(0, 1'b0, 32'h0000_1000, 2'd2, 1'b0, 32'h0, 32'hDEAD_BEEF, 0);
    vec_cnt++; if (r_ack_cyc !== 2) begin err_cnt++; $display("FAIL wr_ack_cycle: got %0d want 2", r_ack_cyc); end
    vec_cnt++; if (r_ack !== 2'b01 || r_err !== 2'b00) begin err_cnt++; $display("FAIL wr_ack_err: got %b/%b want 01/00", r_ack, r_err); end
    vec_cnt++; if (r_rdata !== 32'hDEAD_BEEF) begin err_cnt++; $display("FAIL wr_rdata: got %h want deadbeef", r_rdata); end
    vec_cnt++; if (r_rd_cyc !== 1 || r_wr_cyc !== 0) begin err_cnt++; $display("FAIL wr_strobes: got rd=%0d wr=%0d want 1/0", r_rd_cyc, r_wr_cyc); end
    vec_cnt++; if (r_addr !== 32'h0000_1000 || r_be !== 4'hF) begin err_cnt++; $display("FAIL wr_addr_be: got %h/%h want 00001000/f", r_addr, r_be); end
  endtask

  task automatic test_store_lanes();
    // byte store on lane 3 with two waitrequest cycles
    run_txn(1, 1'b1, 32'h0000_1003, 2'd0, 1'b0, 32'h0000_00AB, 32'h0, 2);
    vec_cnt++; if (r_ack_cyc !== 4) begin err_cnt++; $display("FAIL sb_ack_cycle: got %0d want 4", r_ack_cyc); end
    vec_cnt++; if (r_ack !== 2'b10 || r_err !== 2'b00) begin err_cnt++; $display("FAIL sb_ack_err: got %b/%b want 10/00", r_ack, r_err); end
    vec_cnt++; if (r_wr_cyc !== 3 || r_rd_cyc !== 0) begin err_cnt++; $display("FAIL sb_strobes: got wr=%0d rd=%0d want 3/0", r_wr_cyc, r_rd_cyc); end
    vec_cnt++; if (r_be !== 4'b1000 || r_wd !== 32'hAB00_0000) begin err_cnt++; $display("FAIL sb_be_wd: got %b/%h want 1000/ab000000", r_be, r_wd); end
    vec_cnt++; if (r_addr !== 32'h0000_1000 || r_unstable !== 1'b0) begin err_cnt++; $display("FAIL sb_addr_stable: got %h/%b want 00001000/0", r_addr, r_unstable); end
    // half store on lane 2: upper half of wdata must not leak onto the bus
    run_txn(1, 1'b1, 32'h0000_1002, 2'd1, 1'b0, 32'hFFFF_1234, 32'h0, 0);
    vec_cnt++; if (r_ack_cyc !== 2) begin err_cnt++; $display("FAIL sh_ack_cycle: got %0d want 2", r_ack_cyc); end
    vec_cnt++; if (r_be !== 4'b1100 || r_wd !== 32'h1234_0000) begin err_cnt++; $display("FAIL sh_be_wd: got %b/%h want 1100/12340000", r_be, r_wd); end
  endtask

  task automatic test_load_extend();
    run_txn(1, 1'b0, 32'h0000_2002, 2'd1, 1'b1, 32'h0, 32'h8001_1234, 0);
    vec_cnt++; if (r_rdata !== 32'hFFFF_8001) begin err_cnt++; $display("FAIL lh_signed: got %h want ffff8001", r_rdata); end
    vec_cnt++; if (r_be !== 4'b1100 || r_addr !== 32'h0000_2000) begin err_cnt++; $display("FAIL lh_be_addr: got %b/%h want 1100/00002000", r_be, r_addr); end
    run_txn(1, 1'b0, 32'h0000_2002, 2'd1, 1'b0, 32'h0, 32'h8001_1234, 0);
    vec_cnt++; if (r_rdata !== 32'h0000_8001) begin err_cnt++; $display("FAIL lhu_unsigned: got %h want 00008001", r_rdata); end
    run_txn(0, 1'b0, 32'h0000_2001, 2'd0, 1'b0, 32'h0, 32'h8001_1234, 0);
    vec_cnt++; if (r_rdata !== 32'h0000_0012 || r_be !== 4'b0010) begin err_cnt++; $display("FAIL lbu_lane1: got %h/%b want 00000012/0010", r_rdata, r_be); end
    run_txn(0, 1'b0, 32'h0000_2003, 2'd0, 1'b1, 32'h0, 32'h8001_1234, 1);
    vec_cnt++; if (r_rdata !== 32'hFFFF_FF80 || r_ack_cyc !== 3) begin err_cnt++; $display("FAIL lb_lane3: got %h cyc %0d want ffffff80 cyc 3", r_rdata, r_ack_cyc); end
    run_txn(1, 1'b0, 32'h0000_2004, 2'd2, 1'b1, 32'h0, 32'h8001_1234, 0);
    vec_cnt++; if (r_rdata !== 32'h8001_1234) begin err_cnt++; $display("FAIL lw_noext: got %h want 80011234", r_rdata); end
  endtask

  task automatic test_misaligned();
    run_txn(0, 1'b0, 32'h0000_1002, 2'd2, 1'b0, 32'h0, 32'h0, 0);
    vec_cnt++; if (r_ack_cyc !== 1) begin err_cnt++; $display("FAIL mis_w_cycle: got %0d want 1", r_ack_cyc); end
    vec_cnt++; if (r_ack !== 2'b01 || r_err !== 2'b01) begin err_cnt++; $display("FAIL mis_w_ack_err: got %b/%b want 01/01", r_ack, r_err); end
    vec_cnt++; if (r_rd_cyc !== 0 || r_wr_cyc !== 0) begin err_cnt++; $display("FAIL mis_w_nobus: got rd=%0d wr=%0d want 0/0", r_rd_cyc, r_wr_cyc); end
    run_txn(1, 1'b1, 32'h0000_1001, 2'd1, 1'b0, 32'h1234, 32'h0, 0);
    vec_cnt++; if (r_ack_cyc !== 1 || r_ack !== 2'b10 || r_err !== 2'b10 || r_wr_cyc !== 0) begin
      err_cnt++; $display("FAIL mis_h_store: got cyc %0d ack %b err %b wr %0d want 1/10/10/0", r_ack_cyc, r_ack, r_err, r_wr_cyc);
    end
    // dword size is illegal on a 32-bit bus even when aligned
    run_txn(0, 1'b0, 32'h0000_1000, 2'd3, 1'b0, 32'h0, 32'h0, 0);
    vec_cnt++; if (r_ack_cyc !== 1 || r_err !== 2'b01 || r_rd_cyc !== 0) begin
      err_cnt++; $display("FAIL illegal_dword: got cyc %0d err %b rd %0d want 1/01/0", r_ack_cyc, r_err, r_rd_cyc);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] seq [4];
    logic [1:0] exp [4];
    int n;
    n = 0;
`ifdef ARB_ROUND_ROBIN_EN
    exp[0] = 2'b01; exp[1] = 2'b10; exp[2] = 2'b01; exp[3] = 2'b10;
`else
    exp[0] = 2'b01; exp[1] = 2'b01; exp[2] = 2'b01; exp[3] = 2'b01;
`endif
    for (int i = 0; i < 4; i++) seq[i] = 2'b00;
    // fresh reset so the rotation starts from channel 0
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    bus.readdata = 32'h0BAD_F00D; bus.waitrequest = 1'b0;
    @(posedge clk); #1;
    bus.ch_write = 2'b00; bus.ch_signed = 2'b00;
    bus.ch_addr  = {32'h0000_0020, 32'h0000_0010};
    bus.ch_size  = {2'd2, 2'd2};
    bus.ch_req   = 2'b11;
    for (int c = 0; c < 60 && n < 4; c++) begin
      @(negedge clk);
      if (bus.ch_ack != 2'b00) begin seq[n] = bus.ch_ack; n++; end
    end
    @(posedge clk); #1;
    bus.ch_req = 2'b00;
    vec_cnt++; if (n !== 4) begin err_cnt++; $display("FAIL arb_ack_count: got %0d want 4", n); end
    for (int i = 0; i < 4; i++) begin
      vec_cnt++;
      if (seq[i] !== exp[i]) begin err_cnt++; $display("FAIL arb_grant_%0d: got %b want %b", i, seq[i], exp[i]); end
    end
  endtask

  task automatic test_reset_mid_write();
    bus.waitrequest = 1'b1;
    @(posedge clk); #1;
    bus.ch_write[1] = 1'b1; bus.ch_addr[63:32] = 32'h0000_3000; bus.ch_size[3:2] = 2'd2;
    bus.ch_wdata[63:32] = 32'h55AA_55AA; bus.ch_req[1] = 1'b1;
    repeat (3) @(negedge clk);
    vec_cnt++; if (bus.write !== 1'b1 || bus.byteenable !== 4'hF) begin err_cnt++; $display("FAIL rmw_waiting: got wr=%b be=%h want 1/f", bus.write, bus.byteenable); end
    #2 reset = 1'b0;
    #1;
    vec_cnt++; if (bus.write !== 1'b0 || bus.byteenable !== 4'h0 || bus.busy !== 1'b0) begin
      err_cnt++; $display("FAIL rmw_async_drop: got wr=%b be=%h busy=%b want 0/0/0", bus.write, bus.byteenable, bus.busy);
    end
    bus.ch_req = 2'b00; bus.waitrequest = 1'b0;
    @(negedge clk); reset = 1'b1;
    vec_cnt++; if (dbg_state !== 2'd0) begin err_cnt++; $display("FAIL rmw_idle: got %0d want 0", dbg_state); end
    run_txn(0, 1'b0, 32'h0000_0040, 2'd2, 1'b0, 32'h0, 32'h1357_9BDF, 0);
    vec_cnt++; if (r_ack_cyc !== 2 || r_ack !== 2'b01 || r_rdata !== 32'h1357_9BDF) begin
      err_cnt++; $display("FAIL rmw_after: got cyc %0d ack %b rdata %h want 2/01/13579bdf", r_ack_cyc, r_ack, r_rdata);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset           = 1'b0;
    bus.ch_req      = '0;
    bus.ch_write    = '0;
    bus.ch_addr     = '0;
    bus.ch_size     = '0;
    bus.ch_signed   = '0;
    bus.ch_wdata    = '0;
    bus.waitrequest = 1'b0;
    bus.readdata    = '0;
    test_reset();
    test_word_read();
    test_store_lanes();
    test_load_extend();
    test_misaligned();
    test_back_to_back();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
